get_length_scan: RTL
====================

// Module: get_length_scan
// PURPOSE
//   Parametrised successor to the fixed 64-bit length finder. Takes a WIDTH-bit operand and returns its
//   significant bit length (index of MSB set + 1) or its leading-zero count. The operand is scanned
//   STEP bits per cycle from the MSB down, with early exit at the first nonzero chunk.
//   Used by the RSA datapath to size exponent and modulus loops before modular multiplication.
// PARAMETERS
//   WIDTH  64  operand width; must be a multiple of STEP
//   STEP    8  bits examined per SCAN cycle; NCH = WIDTH/STEP chunks, numbered 0 (LSB) .. NCH-1 (MSB)
//   LEN_W   8  len_out width; must be >= $clog2(WIDTH+1)
// PORTS
//   clk       in   1      rising-edge clock
//   rstn      in   1      asynchronous active-low reset
//   md_start  in   1      start request; sampled only while busy==0
//   md_mode   in   1      0 = bit length, 1 = leading-zero count (WIDTH - length); latched with num_in
//   num_in    in   WIDTH  operand; latched on the accepted md_start edge
//   len_out   out  LEN_W  result; held stable from md_end until the next result is written
//   is_zero   out  1      1 when the latched operand was all zeros; updated together with len_out
//   md_end    out  1      one-cycle completion pulse, registered
//   busy      out  1      1 while state==SCAN
// BEHAVIOUR
//   Reset (async, rstn=0): state=IDLE; len_out=0, is_zero=0, md_end=0, busy=0; operand and mode regs cleared.
//   Reset taken mid-SCAN aborts the operation. No md_end is produced for the aborted operation.
//   FSM states: IDLE, SCAN, DONE.
//     IDLE: md_start=1 -> latch num_in/md_mode, chunk ptr k=NCH-1, go to SCAN.
//     SCAN: on each edge, examine chunk k = opnd[k*STEP +: STEP].
//       nonzero -> L = k*STEP + (highest set bit pos in chunk) + 1; write len_out; go to DONE.
//       zero and k>0 -> k=k-1; stay in SCAN.
//       zero and k==0 -> L=0, is_zero=1; go to DONE.
//       len_out = md_mode ? WIDTH-L : L, zero-extended to LEN_W.
//     DONE: md_end=1 for this single cycle.
//       md_start=1 -> accept a new operation, go to SCAN.
//       md_start=0 -> go to IDLE.
//   Latency: start accepted at edge E0. Result and md_end are registered at edge En.
//     n = NCH - k_top, where k_top = index of the highest nonzero chunk; n = NCH for a zero operand.
//     Range 1..NCH cycles. md_end is high during the cycle following En.
//   md_start while busy=1 is ignored. num_in and md_mode changes during SCAN have no effect.
//   len_out and is_zero change only on the result-writing edge; they are never cleared by a new start.
//   Full-width operand (MSB set): L=WIDTH, len_out=WIDTH (mode 0) or 0 (mode 1), n=1.
//   Chunk priority encoder is combinational within one cycle; no multi-cycle paths.
// TESTING  (defaults WIDTH=64, STEP=8, clk period 10ns)
//   num_in=128255609, mode 0, pulse md_start
//     -> len_out=27, is_zero=0; md_end high exactly 5 cycles after the start edge (chunk 3 is top).
//   Same operand, mode 1 -> len_out=37, same latency.
//   num_in=0, mode 0 -> len_out=0, is_zero=1, latency 8.
//   num_in=1 -> len_out=1, latency 8.
//   num_in=64'hFFFF_FFFF_FFFF_FFFF -> len_out=64, latency 1; in mode 1, len_out=0.
//   Hold md_start=1 continuously with num_in=32'h8000_0000 (len 32), then 0x100 (len 9):
//     -> second operation accepted in the DONE cycle, two md_end pulses, no IDLE cycle between them.
//     -> md_start pulses during SCAN are ignored, busy stays 1.
//   Assert rstn=0 for one cycle mid-SCAN
//     -> all outputs return to 0 immediately, no md_end pulse;
//     -> the next start completes normally.
//   Re-run with WIDTH=32, STEP=4, LEN_W=6, num_in=32'h0000_0010 -> len_out=5, latency 7.

Source files
------------

// File: rtl/get_length_scan.sv
// ---------------------------------------------------------------------------
// get_length_scan
//   Finds the significant bit length (index of the highest set bit + 1) or
//   the leading-zero count of a WIDTH-bit operand. The latched operand is
//   scanned STEP bits per cycle from the MSB chunk downwards, and the scan
//   stops at the first nonzero chunk. The RSA datapath uses the result to
//   size its exponent and modulus loops.
//
// Parameters
//   WIDTH  operand width, a multiple of STEP
//   STEP   bits examined per SCAN cycle (NCH = WIDTH/STEP chunks)
//   LEN_W  result width, at least $clog2(WIDTH+1)
//
// Ports
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   md_start  start request, sampled only while busy is low
//   md_mode   0 = bit length, 1 = leading-zero count; latched with num_in
//   num_in    operand, latched on the accepted start edge
//   len_out   result, held until the next result is written
//   is_zero   latched operand was all zeros; updated together with len_out
//   md_end    one-cycle registered completion pulse
//   busy      high while a scan is in progress
// ---------------------------------------------------------------------------
module get_length_scan #(
  parameter int WIDTH = 64,
  parameter int STEP  = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             md_start,
  input  logic             md_mode,
  input  logic [WIDTH-1:0] num_in,
  output logic [LEN_W-1:0] len_out,
  output logic             is_zero,
  output logic             md_end,
  output logic             busy
);

  localparam int NCH = WIDTH / STEP;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = (STEP > 1) ? $clog2(STEP) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opnd;
  logic             mode;
  logic [KW-1:0]    k;

  logic [STEP-1:0]  chunk;
  logic             hit;
  logic [PW-1:0]    pos;
  int               bit_len;
  logic [LEN_W-1:0] scan_len;
  logic [LEN_W-1:0] zero_len;

  // Chunk currently under examination.
  assign chunk = opnd[k*STEP +: STEP];

  // Priority encoder over one chunk: the ascending loop lets the highest
  // set bit win. Result length is formed in int width, then narrowed.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    hit = 1'b0;
    pos = '0;
    for (int i = 0; i < STEP; i++) begin
      if (chunk[i]) begin
        hit = 1'b1;
        pos = PW'(i);
      end
    end
    bit_len = int'(k) * STEP + int'(pos) + 1;
  end

  assign scan_len = mode ? LEN_W'(WIDTH - bit_len) : LEN_W'(bit_len);
  assign zero_len = mode ? LEN_W'(WIDTH) : '0;

  // NOTE: state uses non-blocking assignments; the operand register is reset
  // too, so no stale operand survives an aborted scan.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      opnd    <= '0;
      mode    <= 1'b0;
      k       <= '0;
      len_out <= '0;
      is_zero <= 1'b0;
      md_end  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      md_end <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start) begin
            opnd  <= num_in;
            mode  <= md_mode;
            k     <= KW'(NCH - 1);
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          if (hit) begin
            len_out <= scan_len;
            is_zero <= 1'b0;
            md_end  <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end else if (k != '0) begin
            k <= k - 1'b1;
          end else begin
            len_out <= zero_len;
            is_zero <= 1'b1;
            md_end  <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end

        DONE: begin
          // A start seen here chains straight into the next scan.
          if (md_start) begin
            opnd  <= num_in;
            mode  <= md_mode;
            k     <= KW'(NCH - 1);
            busy  <= 1'b1;
            state <= SCAN;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
